sub_seq_ctrl: RTL and testbench

//  Byte-serial 32-bit subtract controller. Accepts one A-B-Bin operation over a

---
 rtl/sub_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_sub_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_seq_ctrl.sv
// Byte-serial subtract controller: one A-B-Bin operation sequenced through a single
// SLICE-bit subtractor slice. Optional flag outputs are enabled by defining SUB_SEQ_FLAGS_EN.
module sub_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SEQ_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("sub_seq_ctrl: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_bout;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   w_diff_nxt;
    logic [SLICE:0]     w_slice;
    logic               w_last;
    logic               w_accept;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_idx == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One slice per cycle, computed one bit wider so the top bit is the borrow out.
    always_comb begin
        w_slice = {1'b0, r_a[r_idx*SLICE +: SLICE]}
                - {1'b0, r_b[r_idx*SLICE +: SLICE]}
                - {{SLICE{1'b0}}, r_borrow};
        w_diff_nxt = r_diff;
        w_diff_nxt[r_idx*SLICE +: SLICE] = w_slice[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
        end else if (r_state == S_CALC) begin
            r_diff   <= w_diff_nxt;
            r_borrow <= w_slice[SLICE];
            r_idx    <= r_idx + 1'b1;
            if (w_last) begin
                r_bout <= w_slice[SLICE];
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SUB_SEQ_FLAGS_EN
    logic r_zero;
    logic r_neg;
    logic r_ovf;

    // Flags are captured from the completed difference on the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == S_CALC) && w_last) begin
            r_zero <= (w_diff_nxt == '0);
            r_neg  <= w_diff_nxt[WIDTH-1];
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed testbench for sub_seq_ctrl: reset, latency, borrow chain, hold, abort, back-to-back.
module tb_sub_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
`ifdef SUB_SEQ_FLAGS_EN
    logic        zero;
    logic        neg;
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sub_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_SEQ_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents an operation and returns just after the accepting edge.
    task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic bin_i);
        int n;
        n = 0;
        a = a_i;
        b = b_i;
        bin = bin_i;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic retire;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (diff !== 32'h0) begin n_err++; $display("FAIL reset_diff: got %h want 00000000", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout: got %b want 0", bout); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic;
        int cyc;
        // 5 - 3
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL calc_in_ready: got %b want 0", in_ready); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL latency1: got %0d want 4", cyc); end
        n_cmp++; if (diff !== 32'h0000_0002) begin n_err++; $display("FAIL diff1: got %h want 00000002", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL bout1: got %b want 0", bout); end
        retire();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL retire1_out_valid: got %b want 0", out_valid); end
        // borrow crosses slice 0 into slice 1
        send(32'h0000_0100, 32'h0000_0001, 1'b0);
        wait_done(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL latency2: got %0d want 4", cyc); end
        n_cmp++; if (diff !== 32'h0000_00FF) begin n_err++; $display("FAIL diff2: got %h want 000000ff", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL bout2: got %b want 0", bout); end
        retire();
        // borrow-in alone wraps the full width
        send(32'h0, 32'h0, 1'b1);
        wait_done(cyc);
        n_cmp++; if (diff !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL diff3: got %h want ffffffff", diff); end
        n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL bout3: got %b want 1", bout); end
`ifdef SUB_SEQ_FLAGS_EN
        n_cmp++; if ({zero, neg, ovf} !== 3'b010) begin n_err++; $display("FAIL flags3: got %b want 010", {zero, neg, ovf}); end
`endif
        retire();
    endtask

    task automatic test_hold;
        int cyc;
        send(32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_done(cyc);
        n_cmp++; if (diff !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL diff4: got %h want 7fffffff", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL bout4: got %b want 0", bout); end
`ifdef SUB_SEQ_FLAGS_EN
        n_cmp++; if ({zero, neg, ovf} !== 3'b001) begin n_err++; $display("FAIL flags4: got %b want 001", {zero, neg, ovf}); end
`endif
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        bin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (diff !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL hold_diff[%0d]: got %h want 7fffffff", i, diff); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
            step();
        end
        // Retire and request in the same cycle: the new op must wait for IDLE.
        a = 32'd9;
        b = 32'd4;
        bin = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL same_cycle_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL same_cycle_in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        wait_done(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL latency_after_hold: got %0d want 4", cyc); end
        n_cmp++; if (diff !== 32'd5) begin n_err++; $display("FAIL diff_after_hold: got %h want 00000005", diff); end
        retire();
    endtask

    task automatic test_abort;
        int cyc;
        send(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (diff !== 32'h0) begin n_err++; $display("FAIL abort_diff: got %h want 00000000", diff); end
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got %b want 0", out_valid); end
        send(32'd9, 32'd4, 1'b0);
        wait_done(cyc);
        n_cmp++; if (diff !== 32'd5) begin n_err++; $display("FAIL abort_next_diff: got %h want 00000005", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL abort_next_bout: got %b want 0", bout); end
        retire();
    endtask

    task automatic test_back_to_back;
        logic [32:0] q[$];
        logic [32:0] e;
        int sent;
        int got;
        int cyc;
        int last;
        logic acc;
        sent = 0;
        got = 0;
        cyc = 0;
        last = -1;
        out_ready = 1'b1;
        a = $urandom;
        b = $urandom;
        bin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        while (got < 1000 && cyc < 10000) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b2b_spurious: out_valid with no pending op at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if ({bout, diff} !== e) begin
                        n_err++;
                        $display("FAIL b2b_result[%0d]: got %b_%h want %b_%h", got, bout, diff, e[32], e[31:0]);
                    end
                end
                got++;
            end
            if (acc) begin
                q.push_back({1'b0, a} - {1'b0, b} - {32'h0, bin});
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== 6) begin
                        n_err++;
                        $display("FAIL b2b_interval[%0d]: got %0d want 6", sent, cyc - last);
                    end
                end
                last = cyc;
                sent++;
            end
            step();
            cyc++;
            if (acc) begin
                if (sent == 1000) begin
                    in_valid = 1'b0;
                end else begin
                    a = $urandom;
                    b = $urandom;
                    bin = 1'($urandom_range(0, 1));
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (got !== 1000) begin n_err++; $display("FAIL b2b_count: got %0d want 1000", got); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
